// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: key codes, the row/column key map
// and the scanner state encoding.
package keypad_scanner_pkg;

   localparam logic [3:0] KEY_A = 4'd10;
   localparam logic [3:0] KEY_B = 4'd11;
   localparam logic [3:0] KEY_C = 4'd12;
   localparam logic [3:0] KEY_D = 4'd13;
   localparam logic [3:0] KEY_E = 4'd14;
   localparam logic [3:0] KEY_F = 4'd15;

   // Indexed as KEYMAP[row][col]; '*' maps to E and '#' maps to F.
   localparam logic [3:0] KEYMAP [0:3][0:3] = '{
      '{4'd1, 4'd2, 4'd3, KEY_A},
      '{4'd4, 4'd5, 4'd6, KEY_B},
      '{4'd7, 4'd8, 4'd9, KEY_C},
      '{KEY_E, 4'd0, KEY_F, KEY_D}
   };

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      RELEASE  = 2'd2
   } state_e;

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchroniser for signals arriving asynchronously to clk.
// RST_VAL sets the idle level the flops hold while in reset.
module keypad_scanner_sync2 #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates one active-low column per dwell, debounces
// a single-key press and its release, and emits one Value_en pulse per press.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       Value_en,
   output logic [3:0] KEY_Value,
   output logic       key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

   logic [3:0]       rs;
   logic [DIV_W-1:0] div_q, div_d;
   state_e           state_q, state_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             value_en_q, value_en_d;
   logic [3:0]       key_q, key_d;
   logic             held_q, held_d;

   logic             tick;
   logic             sample_valid;
   logic [1:0]       sample_row;
   logic             match;
   logic             all_up;
   logic [CNT_W-1:0] cnt_inc;
   logic             capture, accept, rotate, released;

   keypad_scanner_sync2 #(.W(4), .RST_VAL(4'b1111)) u_row_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (row_in),
      .q    (rs)
   );

   assign tick         = (div_q == DIV_W'(SCAN_DIV - 1));
   assign sample_valid = $onehot(~rs);
   assign match        = sample_valid && (sample_row == row_q);
   assign all_up       = (rs == 4'b1111);
   assign cnt_inc      = cnt_q + 1'b1;

   always_comb begin
      sample_row = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!rs[i]) sample_row = 2'(i);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_q      <= '0;
         state_q    <= SCAN;
         col_q      <= 2'd0;
         row_q      <= 2'd0;
         cnt_q      <= '0;
         value_en_q <= 1'b0;
         key_q      <= 4'd0;
         held_q     <= 1'b0;
      end else begin
         div_q      <= div_d;
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         value_en_q <= value_en_d;
         key_q      <= key_d;
         held_q     <= held_d;
      end
   end

   // Next-state: the column only rotates on ticks that leave or stay in SCAN.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      accept   = 1'b0;
      rotate   = 1'b0;
      released = 1'b0;
      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (sample_valid) begin
                  capture = 1'b1;
                  if (DEBOUNCE_TICKS == 1) begin
                     accept  = 1'b1;
                     state_d = RELEASE;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  rotate = 1'b1;
               end
            end
            DEBOUNCE: begin
               if (!match) begin
                  rotate  = 1'b1;
                  state_d = SCAN;
               end else if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                  accept  = 1'b1;
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (all_up && (cnt_inc == CNT_W'(DEBOUNCE_TICKS))) begin
                  released = 1'b1;
                  rotate   = 1'b1;
                  state_d  = SCAN;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   always_comb begin
      div_d      = tick ? '0 : div_q + 1'b1;
      col_d      = rotate ? col_q + 2'd1 : col_q;
      row_d      = capture ? sample_row : row_q;
      cnt_d      = cnt_q;
      if (tick) begin
         unique case (state_q)
            SCAN:     cnt_d = capture ? CNT_W'(1) : '0;
            DEBOUNCE: cnt_d = match ? cnt_inc : '0;
            RELEASE:  cnt_d = all_up ? cnt_inc : '0;
            default:  cnt_d = '0;
         endcase
      end
      if (accept || released) cnt_d = '0;
      value_en_d = accept;
      key_d      = accept ? KEYMAP[sample_row][col_q] : key_q;
      held_d     = accept ? 1'b1 : (released ? 1'b0 : held_q);
   end

   assign col_out   = ~(4'b0001 << col_q);
   assign Value_en  = value_en_q;
   assign KEY_Value = key_q;
   assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives row_in from the
// pressed-key set, and a tick-level behavioural model predicts every output.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DT       = 3;
   localparam int M_SCAN   = 0;
   localparam int M_DEB    = 1;
   localparam int M_REL    = 2;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       Value_en;
   logic [3:0] KEY_Value;
   logic       key_held;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DT)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .row_in    (row_in),
      .col_out   (col_out),
      .Value_en  (Value_en),
      .KEY_Value (KEY_Value),
      .key_held  (key_held)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   bit         pressed [4][4];
   int         dut_pulses;
   logic [3:0] dut_key;

   int         m_mode, m_col, m_row, m_cnt, m_cyc;
   logic       m_en;
   logic [3:0] m_key;
   logic       m_held;

   function automatic logic [3:0] keycode(int r, int c);
      if (c == 3) return (r == 3) ? 4'd13 : 4'(10 + r);
      if (r == 3) return (c == 0) ? 4'd14 : ((c == 1) ? 4'd0 : 4'd15);
      return 4'(3 * r + c + 1);
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_keys();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
   endtask

   task automatic model_reset();
      m_mode = M_SCAN; m_col = 0; m_row = 0; m_cnt = 0; m_cyc = 0;
      m_en = 1'b0; m_key = 4'd0; m_held = 1'b0;
   endtask

   // One dwell's decision, taken from the pressed set in the model's own column.
   task automatic model_tick();
      int lows;
      int r;
      lows = 0;
      r = 0;
      for (int i = 0; i < 4; i++) if (pressed[i][m_col]) begin lows++; r = i; end
      case (m_mode)
         M_SCAN: begin
            if (lows == 1) begin m_row = r; m_cnt = 1; m_mode = M_DEB; end
            else m_col = (m_col + 1) % 4;
         end
         M_DEB: begin
            if (lows == 1 && r == m_row) m_cnt++;
            else begin m_cnt = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 4; end
         end
         default: begin
            m_cnt = (lows == 0) ? m_cnt + 1 : 0;
            if (m_cnt == DT) begin
               m_held = 1'b0; m_cnt = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 4;
            end
         end
      endcase
      if (m_mode == M_DEB && m_cnt == DT) begin
         m_en = 1'b1; m_key = keycode(m_row, m_col); m_held = 1'b1;
         m_cnt = 0; m_mode = M_REL;
      end
   endtask

   task automatic model_edge();
      m_cyc++;
      m_en = 1'b0;
      if (m_cyc % SCAN_DIV == 0) model_tick();
   endtask

   task automatic drive_rows();
      logic [3:0] r;
      r = 4'hF;
      for (int c = 0; c < 4; c++)
         if (col_out[c] === 1'b0)
            for (int i = 0; i < 4; i++) if (pressed[i][c]) r[i] = 1'b0;
      row_in = r;
   endtask

   task automatic cycle();
      logic [3:0] exp_col;
      @(posedge clk);
      #1;
      if (rstn) model_edge(); else model_reset();
      drive_rows();
      if (Value_en === 1'b1) begin dut_pulses++; dut_key = KEY_Value; end
      exp_col = ~(4'b0001 << m_col);
      check("col_out", col_out, exp_col);
      check("Value_en", {3'b000, Value_en}, {3'b000, m_en});
      check("KEY_Value", KEY_Value, m_key);
      check("key_held", {3'b000, key_held}, {3'b000, m_held});
   endtask

   task automatic tick();
      do cycle(); while (m_cyc % SCAN_DIV != 0);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_debounce(input string tag, input int budget);
      for (int i = 0; i < budget && m_mode != M_DEB; i++) tick();
      n_cmp++;
      assert (m_mode == M_DEB) else begin
         n_bad++;
         $error("FAIL %s: no debounce entry within %0d ticks", tag, budget);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"}, col_out, 4'b1110);
      check({tag, "_en"}, {3'b000, Value_en}, 4'd0);
      check({tag, "_key"}, KEY_Value, 4'd0);
      check({tag, "_held"}, {3'b000, key_held}, 4'd0);
   endtask

   initial begin
      clear_keys();
      model_reset();
      dut_pulses = 0;
      dut_key = 4'd0;
      row_in = 4'hF;
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1 check_reset_outputs("rst");

      // Reset held with rows toggling.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         row_in = 4'($urandom);
         #1 check_reset_outputs("rst_hold");
      end
      @(negedge clk);
      row_in = 4'hF;
      rstn = 1'b1;
      ticks(6);

      // Clean press row1/col2.
      dut_pulses = 0;
      pressed[1][2] = 1'b1;
      ticks(20);
      check("s2_pulses", 4'(dut_pulses), 4'd1);
      check("s2_key", dut_key, 4'd6);
      check("s2_frozen_col", col_out, 4'b1011);
      check("s2_held", {3'b000, key_held}, 4'd1);
      clear_keys();
      ticks(DT - 1);
      check("s2_still_held", {3'b000, key_held}, 4'd1);
      tick();
      check("s2_released", {3'b000, key_held}, 4'd0);
      ticks(4);

      // Bouncing press row0/col3.
      dut_pulses = 0;
      pressed[0][3] = 1'b1;
      wait_debounce("s3_detect", 8);
      pressed[0][3] = 1'b0;
      tick();
      check("s3_no_pulse", 4'(dut_pulses), 4'd0);
      pressed[0][3] = 1'b1;
      ticks(20);
      check("s3_pulses", 4'(dut_pulses), 4'd1);
      check("s3_key", dut_key, 4'd10);
      clear_keys();
      ticks(DT + 2);

      // Long hold row3/col0, then a second press.
      dut_pulses = 0;
      pressed[3][0] = 1'b1;
      ticks(50);
      check("s4_single", 4'(dut_pulses), 4'd1);
      check("s4_key", dut_key, 4'd14);
      clear_keys();
      ticks(DT + 2);
      check("s4_released", {3'b000, key_held}, 4'd0);
      pressed[3][0] = 1'b1;
      ticks(20);
      check("s4_second", 4'(dut_pulses), 4'd2);
      check("s4_key2", dut_key, 4'd14);
      clear_keys();
      ticks(DT + 2);

      // Two rows in column 1 are rejected until one lets go.
      dut_pulses = 0;
      pressed[0][1] = 1'b1;
      pressed[2][1] = 1'b1;
      ticks(12);
      check("s5_ghost", 4'(dut_pulses), 4'd0);
      pressed[2][1] = 1'b0;
      ticks(12);
      check("s5_pulses", 4'(dut_pulses), 4'd1);
      check("s5_key", dut_key, 4'd2);
      clear_keys();
      ticks(DT + 2);

      // Reset during debounce of row2/col1, key still held afterwards.
      dut_pulses = 0;
      pressed[2][1] = 1'b1;
      wait_debounce("s6_detect", 8);
      tick();
      cycle();
      @(negedge clk);
      rstn = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("s6_rst");
      repeat (5) cycle();
      @(negedge clk);
      rstn = 1'b1;
      check("s6_no_pulse", 4'(dut_pulses), 4'd0);
      ticks(20);
      check("s6_pulses", 4'(dut_pulses), 4'd1);
      check("s6_key", dut_key, 4'd8);
      clear_keys();
      ticks(DT + 2);

      // Random presses, holds, rollovers and releases against the model.
      for (int n = 0; n < 40; n++) begin
         pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
         if ($urandom_range(0, 3) == 0)
            pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
         ticks($urandom_range(1, 25));
         if ($urandom_range(0, 2) == 0) begin
            clear_keys();
            pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            ticks($urandom_range(1, 10));
         end
         clear_keys();
         ticks($urandom_range(1, 8));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
